// File: rtl/pwm11_capture_if.sv
// PWM capture bus: sampled waveform in, duty/period measurement and status out.
// The source side drives PWM_in; the capture block drives the result strobe and fields.
interface pwm11_capture_if;
  logic        PWM_in;
  logic [10:0] duty;
  logic [12:0] period;
  logic        duty_vld;
  logic        per_err;
  logic        stuck;

  modport master (output PWM_in, input duty, period, duty_vld, per_err, stuck);
  modport slave  (input PWM_in, output duty, period, duty_vld, per_err, stuck);
endinterface

// File: rtl/pwm11_capture.sv
// Measures high time and rise-to-rise period of an async PWM input; flags period errors and stuck input.
// Strobe 3 edges after the input edge; no backpressure, results hold between single-cycle strobes.
module pwm11_capture #(
  parameter int PERIOD  = 2048,
  parameter int TOL     = 2,
  parameter int TIMEOUT = 4096
) (
  input logic             clk,
  input logic             rst_n,
  pwm11_capture_if.slave  cap
);

  typedef enum logic [1:0] {IDLE, MEAS, STUCK} state_t;

  localparam logic [12:0] CNT_MAX = 13'h1FFF;
  localparam logic [12:0] TO_CNT  = 13'(TIMEOUT);

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [12:0] per_cnt_q, per_cnt_d;
  logic [12:0] hi_cnt_q, hi_cnt_d;
  logic [10:0] duty_q, duty_d;
  logic [12:0] period_q, period_d;
  logic        vld_q, vld_d;
  logic        per_err_q, per_err_d;
  logic        stuck_q, stuck_d;

  logic        rise, hi, timeout, per_bad;
  logic signed [31:0] per_s;

  assign rise    = s2_q & ~s3_q;
  assign hi      = s2_q;
  assign timeout = (per_cnt_q == TO_CNT);
  assign per_s   = $signed({19'd0, per_cnt_q});
  assign per_bad = (per_s > PERIOD + TOL) || (per_s < PERIOD - TOL);

  always_comb begin
    per_cnt_d = rise ? 13'd1 : ((per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + 13'd1);
    hi_cnt_d  = hi_cnt_q;
    if (rise)
      hi_cnt_d = 13'd1;
    else if (hi && hi_cnt_q != CNT_MAX)
      hi_cnt_d = hi_cnt_q + 13'd1;
  end

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    period_d  = period_q;
    vld_d     = 1'b0;
    per_err_d = per_err_q;
    stuck_d   = stuck_q;
    case (state_q)
      IDLE, MEAS: begin
        if (rise) begin
          state_d = MEAS;
          if (state_q == MEAS) begin
            vld_d     = 1'b1;
            duty_d    = (hi_cnt_q > 13'd2047) ? 11'h7FF : hi_cnt_q[10:0];
            period_d  = per_cnt_q;
            per_err_d = per_bad;
            stuck_d   = 1'b0;
          end
        end else if (timeout) begin
          state_d   = STUCK;
          vld_d     = 1'b1;
          duty_d    = hi ? 11'h7FF : 11'h000;
          period_d  = 13'd0;
          per_err_d = 1'b1;
          stuck_d   = 1'b1;
        end
      end
      // stuck is only cleared by the next genuine measurement
      STUCK: if (rise) state_d = MEAS;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      per_cnt_q <= 13'd0;
      hi_cnt_q  <= 13'd0;
      duty_q    <= 11'd0;
      period_q  <= 13'd0;
      vld_q     <= 1'b0;
      per_err_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= cap.PWM_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      vld_q     <= vld_d;
      per_err_q <= per_err_d;
      stuck_q   <= stuck_d;
    end
  end

  assign cap.duty     = duty_q;
  assign cap.period   = period_q;
  assign cap.duty_vld = vld_q;
  assign cap.per_err  = per_err_q;
  assign cap.stuck    = stuck_q;

endmodule

// File: tb/tb_pwm11_capture.sv
// Directed bench for pwm11_capture: vector table of PWM pulses plus stuck and reset sequences.
module tb_pwm11_capture;

  typedef struct {
    int hi;
    int per;
    int duty;
    bit err;
  } vec_t;

  typedef struct {
    int duty;
    int period;
    bit err;
    bit stk;
    int cyc;
  } stb_t;

  localparam int NV = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  stb_t q[$];
  vec_t vecs[NV];

  pwm11_capture_if bus ();

  pwm11_capture #(.PERIOD(2048), .TOL(2), .TIMEOUT(4096)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cap   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.duty_vld === 1'b1) begin
      stb_t s;
      s.duty = int'(bus.duty);
      s.period = int'(bus.period);
      s.err = bus.per_err;
      s.stk = bus.stuck;
      s.cyc = cyc;
      q.push_back(s);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic chk_strobe(input string name, input int idx, input int duty_lo, input int duty_hi,
                            input int period, input bit err, input bit stk);
    if (idx >= q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: strobe %0d missing, got %0d strobes", name, idx, q.size());
    end else begin
      chk({name, " duty"}, q[idx].duty, duty_lo, duty_hi);
      chk({name, " period"}, q[idx].period, period, period);
      chk({name, " per_err"}, int'(q[idx].err), int'(err), int'(err));
      chk({name, " stuck"}, int'(q[idx].stk), int'(stk), int'(stk));
    end
  endtask

  initial begin
    int base;
    int last_cyc;

    vecs[0] = '{1024, 2048, 1024, 1'b0};
    vecs[1] = '{1024, 2048, 1024, 1'b0};
    vecs[2] = '{1024, 2048, 1024, 1'b0};
    vecs[3] = '{1,    2048, 1,    1'b0};
    vecs[4] = '{2047, 2048, 2047, 1'b0};
    vecs[5] = '{2100, 4000, 2047, 1'b1};
    vecs[6] = '{1000, 2051, 1000, 1'b1};
    vecs[7] = '{1000, 2050, 1000, 1'b0};
    vecs[8] = '{1000, 2045, 1000, 1'b1};
    vecs[9] = '{1000, 2046, 1000, 1'b0};

    // Reset held for two edges while the input toggles
    bus.PWM_in = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    bus.PWM_in = 1'b1;
    @(posedge clk);
    #2;
    bus.PWM_in = 1'b0;
    chk("reset duty", int'(bus.duty), 0, 0);
    chk("reset period", int'(bus.period), 0, 0);
    chk("reset duty_vld", int'(bus.duty_vld), 0, 0);
    chk("reset per_err", int'(bus.per_err), 0, 0);
    chk("reset stuck", int'(bus.stuck), 0, 0);
    rst_n = 1'b1;
    step(20);
    chk("no strobe in idle", q.size(), 0, 0);

    for (int i = 0; i < NV; i++) begin
      bus.PWM_in = 1'b1;
      step(vecs[i].hi);
      bus.PWM_in = 1'b0;
      step(vecs[i].per - vecs[i].hi);
    end
    // Closing rise reports the last vector, then input sticks low
    bus.PWM_in = 1'b1;
    step(1000);
    bus.PWM_in = 1'b0;
    step(4100);

    for (int i = 0; i < NV; i++)
      chk_strobe($sformatf("vec%0d", i), i, vecs[i].duty - 1, vecs[i].duty + 1,
                 vecs[i].per, vecs[i].err, 1'b0);
    if (q.size() >= 3) begin
      chk("strobe spacing 0-1", q[1].cyc - q[0].cyc, 2048, 2048);
      chk("strobe spacing 1-2", q[2].cyc - q[1].cyc, 2048, 2048);
    end
    chk_strobe("stuck low", NV, 0, 0, 0, 1'b1, 1'b1);
    if (q.size() > NV)
      chk("stuck low delay", q[NV].cyc - q[NV-1].cyc, 4096, 4096);
    chk("single stuck strobe", q.size(), NV + 1, NV + 1);
    chk("stuck level low", int'(bus.stuck), 1, 1);

    // Resume, then stick high
    bus.PWM_in = 1'b1;
    step(5000);
    chk("no strobe on resume rise", q.size() >= NV + 2 ? q[NV+1].period : -1, 0, 0);
    chk_strobe("stuck high", NV + 1, 2047, 2047, 0, 1'b1, 1'b1);
    chk("stuck high count", q.size(), NV + 2, NV + 2);
    bus.PWM_in = 1'b0;
    step(100);
    bus.PWM_in = 1'b1;
    step(10);
    chk("stuck holds after first rise", int'(bus.stuck), 1, 1);
    chk("no strobe leaving stuck", q.size(), NV + 2, NV + 2);
    step(1014);
    bus.PWM_in = 1'b0;
    step(1024);
    bus.PWM_in = 1'b1;
    step(500);
    chk_strobe("recovered", NV + 2, 1023, 1025, 2048, 1'b0, 1'b0);
    chk("stuck cleared", int'(bus.stuck), 0, 0);

    // Reset in the middle of a high phase
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("midreset duty", int'(bus.duty), 0, 0);
    chk("midreset period", int'(bus.period), 0, 0);
    chk("midreset duty_vld", int'(bus.duty_vld), 0, 0);
    chk("midreset per_err", int'(bus.per_err), 0, 0);
    chk("midreset stuck", int'(bus.stuck), 0, 0);
    rst_n = 1'b1;
    base = q.size();
    step(300);
    bus.PWM_in = 1'b0;
    step(1748);
    chk("no strobe after one rise", q.size() - base, 0, 0);
    last_cyc = cyc;
    bus.PWM_in = 1'b1;
    step(10);
    chk("strobe after second rise", q.size() - base, 1, 1);
    chk_strobe("post reset", base, 299, 301, 2048, 1'b0, 1'b0);
    if (q.size() > base)
      chk("post reset latency", q[base].cyc - last_cyc, 1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm11_capture.md
# pwm11_capture

Receive-side counterpart of the 11-bit PWM generator. It samples an asynchronous PWM waveform, measures high time and period in `clk` cycles, and reports an 11-bit duty word. It detects period errors and stuck-at-0/1 inputs. It sits on the feedback and test path: it checks motor-drive PWM in loopback and decodes externally supplied PWM commands.

## Interface
- `PERIOD`, default 2048: nominal PWM period in `clk` cycles.
- `TOL`, default 2: allowed period deviation (±cycles) before `per_err`.
- `TIMEOUT`, default 4096: cycles without a rising edge before a stuck condition is declared. Must be ≤ 8191.
- `clk` input, 1 bit: system clock. Single clock domain.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `PWM_in` input, 1 bit: PWM waveform, asynchronous to `clk`.
- `duty` output, 11 bits: measured high time, saturated to 2047.
- `period` output, 13 bits: measured rise-to-rise period in cycles.
- `duty_vld` output, 1 bit: single-cycle strobe that qualifies `duty`, `period`, `per_err` and `stuck`.
- `per_err` output, 1 bit: last measured period was outside `PERIOD`±`TOL`.
- `stuck` output, 1 bit: input has had no rising edge for `TIMEOUT` cycles.

## Operation
- **Input conditioning.** Two-flop synchronizer (`s1`, `s2`) followed by a history flop `s3`.
  - `rise` = `s2 & ~s3`.
  - `hi` = `s2`.
- **Counters.** Both are 13-bit and saturate at 8191.
  - `per_cnt` loads 1 on `rise`; otherwise it increments.
  - `hi_cnt` loads 1 on `rise`; otherwise it increments while `hi`, and holds while low.
  - At a rise, the values held are: `per_cnt` = cycles since the previous rise; `hi_cnt` = high cycles in that period.
- **States.**
  - `IDLE` (reset state): no rise seen yet.
  - `MEAS`: at least one rise seen; a measurement is in progress.
  - `STUCK`: timeout has fired.
- **Transitions.**
  - `IDLE` → `MEAS` on `rise`. No strobe.
  - `MEAS` → `MEAS` on `rise`:
    - strobe `duty_vld`;
    - `duty` = min(`hi_cnt`, 2047);
    - `period` = `per_cnt`;
    - `per_err` = (|`per_cnt` − `PERIOD`| > `TOL`);
    - `stuck` = 0.
  - `STUCK` → `MEAS` on `rise`. No strobe; `stuck` stays 1 until the next valid measurement.
  - `IDLE`/`MEAS` → `STUCK` when `per_cnt` == `TIMEOUT` and no `rise`:
    - strobe `duty_vld`;
    - `stuck` = 1;
    - `duty` = `hi` ? 2047 : 0;
    - `period` = 0;
    - `per_err` = 1.
  - In `STUCK`, counters keep running (saturating) and no further strobes are issued.
- **Simultaneous events.** If `rise` occurs in the same cycle `per_cnt` == `TIMEOUT`, `rise` wins and a normal measurement is reported.
- **Falling edges** need no explicit detection: `hi_cnt` freezes on its own.
- **Reset.** Synchronous: on a rising `clk` edge with `rst_n` = 0, everything clears.
  - `s1`/`s2`/`s3` = 0, counters = 0, state = `IDLE`.
  - `duty` = 0, `period` = 0, `duty_vld` = 0, `per_err` = 0, `stuck` = 0.
  - Reset mid-measurement discards the partial measurement; the first strobe after reset needs two rises.

## Timing
- All outputs are registered and update on the same edge as the `duty_vld` rise. Values hold between strobes.
- A `PWM_in` transition first sampled by `s1` at edge e0:
  - `rise` is true in the cycle after edge e1;
  - the `duty_vld` strobe is high in the cycle after edge e2 (3-edge latency).
- `duty_vld` is high for exactly one cycle per event. Steady nominal input produces one strobe every `PERIOD` cycles.
- Pulses shorter than one `clk` cycle may be missed. No deglitching is required.
- The one cycle of synchronizer skew is identical for both edges, so measured high time equals true high time ±1 cycle.

## Test plan
- Reset: hold `rst_n` = 0 for 2 edges with `PWM_in` toggling → all outputs 0, no `duty_vld`, state `IDLE`.
- Loopback from the PWM generator at duty 0x400, period 2048 → first strobe after the second rise. `duty` = 0x400 (±1), `period` = 2048, `per_err` = 0, strobes every 2048 cycles.
- Duty sweep 0x001, 0x7FF → `duty` 1 and 2047 (±1). A 2100-cycle high pulse inside a 4000-cycle period → `duty` = 2047 (saturated), `period` = 4000, `per_err` = 1.
- Period 2051 and 2050 with `TOL` = 2 → `per_err` = 1 and 0 respectively.
- Hold `PWM_in` low for 5000 cycles after a valid measurement → a single strobe 4096 cycles after the last rise with `stuck` = 1, `duty` = 0, `period` = 0, `per_err` = 1. Repeat with input held high → `duty` = 2047. Resume PWM → `stuck` clears on the second rise.
- Assert `rst_n` = 0 mid-high-phase → outputs clear on that edge. After release, no strobe until two rises have been seen.
